// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// default frame sync byte and memory depth.
package imem_pkg;

   localparam int unsigned IMEM_SIZE = 1024;
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_LEN_LO = 3'd3,
      ST_DATA   = 3'd4,
      ST_CSUM   = 3'd5
   } state_t;

   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/imem_load_timeout.sv
// Loadable down-counter for byte-gap supervision: kick reloads LIMIT,
// expire flags the LIMIT-th consecutive enabled cycle without a kick.
module imem_load_timeout #(
   parameter int unsigned LIMIT = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic kick,
   output logic expire
);

   localparam int unsigned W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (kick)
         cnt_d = W'(LIMIT);
      else if (en && cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   // Fires on the cycle whose decrement would reach zero.
   assign expire = en && !kick && (cnt_q == W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory write sequencer: framed UART download with length and
// checksum checks, plus a full-memory clear. Holds the CPU while writing.
module imem_load_ctrl
   import imem_pkg::*;
#(
   parameter int unsigned SIZE    = IMEM_SIZE,
   parameter logic [7:0]  SYNC    = SYNC_BYTE,
   parameter int unsigned TIMEOUT = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_req,
   input  logic        uart_v,
   input  logic [7:0]  uart_d,
   output logic        im_we,
   output logic [31:0] im_wa,
   output logic [31:0] im_wd,
   output logic        cpu_hold,
   output logic        busy,
   output logic        load_done,
   output logic        load_err
);

   localparam logic [16:0] SIZE_L  = 17'(SIZE);
   localparam logic [31:0] LAST_WA = 32'(SIZE - 1);

   state_t      state_q, state_d;
   logic        im_we_q, im_we_d;
   logic [31:0] im_wa_q, im_wa_d;
   logic [31:0] im_wd_q, im_wd_d;
   logic        hold_q, hold_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  csum_q, csum_d;
   logic        in_frame, tmo_expire;

   assign in_frame = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                     (state_q == ST_DATA)   || (state_q == ST_CSUM);

   imem_load_timeout #(.LIMIT(TIMEOUT)) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .en     (in_frame),
      .kick   (uart_v),
      .expire (tmo_expire)
   );

   always_comb begin
      state_d    = state_q;
      im_we_d    = 1'b0;
      im_wa_d    = im_wa_q;
      im_wd_d    = im_wd_q;
      done_d     = done_q;
      err_d      = err_q;
      byte_cnt_d = byte_cnt_q;
      word_cnt_d = word_cnt_q;
      len_d      = len_q;
      csum_d     = csum_q;
      case (state_q)
         ST_IDLE: begin
            if (clear_req) begin
               state_d = ST_CLEAR;
               im_we_d = 1'b1;
               im_wa_d = '0;
               im_wd_d = '0;
            end else if (uart_v && uart_d == SYNC) begin
               state_d = ST_LEN_HI;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         ST_CLEAR: begin
            if (im_wa_q == LAST_WA) begin
               state_d = ST_IDLE;
               im_wa_d = '0;
            end else begin
               im_we_d = 1'b1;
               im_wa_d = im_wa_q + 32'd1;
            end
         end
         ST_LEN_HI: begin
            if (uart_v) begin
               len_d   = {uart_d, 8'h00};
               state_d = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (uart_v) begin
               len_d = {len_q[15:8], uart_d};
               if (len_d == 16'd0 || {1'b0, len_d} > SIZE_L) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_DATA;
                  word_cnt_d = '0;
                  byte_cnt_d = '0;
                  csum_d     = '0;
               end
            end
         end
         ST_DATA: begin
            // The write of the final word occupies one DATA cycle so that
            // im_we is never seen in CSUM; a byte landing there is the checksum.
            if (im_we_q && word_cnt_q == len_q) begin
               if (uart_v) begin
                  if (uart_d == csum_q) done_d = 1'b1;
                  else                  err_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_CSUM;
               end
            end else if (uart_v) begin
               im_wd_d    = {im_wd_q[23:0], uart_d};
               csum_d     = csum_add(csum_q, uart_d);
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  im_we_d    = 1'b1;
                  im_wa_d    = {16'h0000, word_cnt_q};
                  word_cnt_d = word_cnt_q + 16'd1;
               end
            end
         end
         ST_CSUM: begin
            if (uart_v) begin
               if (uart_d == csum_q) done_d = 1'b1;
               else                  err_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A gap timeout abandons the frame; a half-assembled word is dropped.
      if (in_frame && tmo_expire) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
         im_we_d = 1'b0;
      end
      hold_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         im_we_q    <= 1'b0;
         im_wa_q    <= '0;
         im_wd_q    <= '0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         byte_cnt_q <= '0;
         word_cnt_q <= '0;
         len_q      <= '0;
         csum_q     <= '0;
      end else begin
         state_q    <= state_d;
         im_we_q    <= im_we_d;
         im_wa_q    <= im_wa_d;
         im_wd_q    <= im_wd_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
         byte_cnt_q <= byte_cnt_d;
         word_cnt_q <= word_cnt_d;
         len_q      <= len_d;
         csum_q     <= csum_d;
      end
   end

   assign im_we     = im_we_q;
   assign im_wa     = im_wa_q;
   assign im_wd     = im_wd_q;
   assign cpu_hold  = hold_q;
   assign busy      = hold_q;
   assign load_done = done_q;
   assign load_err  = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: clear, good/bad frames, length limits,
// byte-gap timeout and request/reset races, with a write-port scoreboard.
module tb_imem_load_ctrl;

   localparam int unsigned SIZE = 1024;
   localparam int unsigned TO   = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear_req;
   logic        uart_v;
   logic [7:0]  uart_d;
   logic        im_we;
   logic [31:0] im_wa;
   logic [31:0] im_wd;
   logic        cpu_hold;
   logic        busy;
   logic        load_done;
   logic        load_err;

   int n_checks = 0;
   int n_err    = 0;

   logic [63:0] wr_q[$];
   logic [63:0] exp_q[$];
   logic [7:0]  frame[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   imem_load_ctrl #(.SIZE(SIZE), .SYNC(8'hA5), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear_req (clear_req),
      .uart_v    (uart_v),
      .uart_d    (uart_d),
      .im_we     (im_we),
      .im_wa     (im_wa),
      .im_wd     (im_wd),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .load_done (load_done),
      .load_err  (load_err)
   );

   // Write-port monitor, sampled mid-cycle.
   always @(negedge clk)
      if (im_we === 1'b1) wr_q.push_back({im_wa, im_wd});

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
         check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
      wr_q.delete();
      exp_q.delete();
   endtask

   task automatic check_idle(input string tag, input logic done_exp, input logic err_exp);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_hold"}, cpu_hold, 1'b0);
      check({tag, "_done"}, load_done, done_exp);
      check({tag, "_err"}, load_err, err_exp);
   endtask

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      uart_v = 1'b1;
      uart_d = b;
      @(negedge clk);
      uart_v = 1'b0;
      uart_d = 8'h00;
   endtask

   task automatic send_frame();
      for (int i = 0; i < frame.size(); i++) send_byte(frame[i]);
      frame.delete();
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int bad;
      rst       = 1'b1;
      clear_req = 1'b0;
      uart_v    = 1'b0;
      uart_d    = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_we", im_we, 1'b0);
      check("rst_wa", im_wa, 32'h0);
      check("rst_wd", im_wd, 32'h0);
      check_idle("rst", 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Full clear: SIZE consecutive zero writes at addresses 0..SIZE-1.
      pulse_clear();
      check("clr_busy", busy, 1'b1);
      check("clr_hold", cpu_hold, 1'b1);
      bad = 0;
      for (int i = 0; i < SIZE; i++) begin
         if (!(im_we === 1'b1 && im_wa === 32'(i) && im_wd === 32'h0)) bad++;
         @(negedge clk);
      end
      check("clr_seq_bad", 64'(bad), 64'd0);
      check("clr_end_we", im_we, 1'b0);
      check("clr_end_wa", im_wa, 32'h0);
      check_idle("clr_end", 1'b0, 1'b0);
      wr_q.delete();

      // Good frame. Checksum: DE+AD+BE+EF+00+00+00+13 = 0x34B -> 0x4B.
      send_byte(8'hA5);
      check("good_sync_hold", cpu_hold, 1'b1);
      check("good_sync_busy", busy, 1'b1);
      frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                8'h00, 8'h00, 8'h00, 8'h13, 8'h4B};
      send_frame();
      check_idle("good", 1'b1, 1'b0);
      exp_q.push_back({32'd0, 32'hDEADBEEF});
      exp_q.push_back({32'd1, 32'h00000013});
      check_writes("good");

      // Same payload, wrong checksum: words still land, error reported.
      frame = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
      send_frame();
      check_idle("badcs", 1'b0, 1'b1);
      exp_q.push_back({32'd0, 32'hDEADBEEF});
      exp_q.push_back({32'd1, 32'h00000013});
      check_writes("badcs");

      // LEN = 1025 is one past the memory depth.
      send_byte(8'hA5);
      check("len_big_sync_err_clr", load_err, 1'b0);
      frame = '{8'h04, 8'h01};
      send_frame();
      check_idle("len_big", 1'b0, 1'b1);
      check_writes("len_big");

      // LEN = 0.
      send_byte(8'hA5);
      check("len_zero_sync_err_clr", load_err, 1'b0);
      check("len_zero_sync_busy", busy, 1'b1);
      frame = '{8'h00, 8'h00};
      send_frame();
      check_idle("len_zero", 1'b0, 1'b1);
      check_writes("len_zero");

      // Byte-gap timeout with half a word assembled.
      frame = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD};
      send_frame();
      repeat (TO - 1) @(negedge clk);
      check("tmo_before_busy", busy, 1'b1);
      @(negedge clk);
      check_idle("tmo", 1'b0, 1'b1);
      check_writes("tmo");

      // clear_req and SYNC in the same cycle: clear wins, flags untouched.
      @(negedge clk);
      clear_req = 1'b1;
      uart_v    = 1'b1;
      uart_d    = 8'hA5;
      @(negedge clk);
      clear_req = 1'b0;
      uart_v    = 1'b0;
      uart_d    = 8'h00;
      check("race_busy", busy, 1'b1);
      check("race_we", im_we, 1'b1);
      check("race_wa", im_wa, 32'h0);
      check("race_err_kept", load_err, 1'b1);
      repeat (SIZE) @(negedge clk);
      check_idle("race_end", 1'b0, 1'b1);
      check("race_wr_count", 64'(wr_q.size()), 64'(SIZE));
      wr_q.delete();

      // clear_req mid-frame is dropped. Checksum 11+22+33+44 = 0xAA.
      frame = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
      send_frame();
      pulse_clear();
      check("clrdata_busy", busy, 1'b1);
      check("clrdata_we", im_we, 1'b0);
      frame = '{8'h33, 8'h44, 8'hAA};
      send_frame();
      repeat (4) @(negedge clk);
      check_idle("clrdata", 1'b1, 1'b0);
      exp_q.push_back({32'd0, 32'h11223344});
      check_writes("clrdata");

      // Asynchronous reset partway through the second word.
      frame = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
      send_frame();
      check("rstmid_pre_busy", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rstmid_we", im_we, 1'b0);
      check("rstmid_wa", im_wa, 32'h0);
      check("rstmid_wd", im_wd, 32'h0);
      check_idle("rstmid", 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      frame = '{8'h00, 8'h00, 8'h02, 8'h4B};
      send_frame();
      repeat (4) @(negedge clk);
      check_idle("rstmid_after", 1'b0, 1'b0);
      exp_q.push_back({32'd0, 32'hDEADBEEF});
      check_writes("rstmid");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
